lut_mult_share_ctrl: RTL and testbench

//  Round-robin scheduler that shares one 8-bit LUT constant multiplier among NUM_REQ requesters.
//  - Each requester uses a valid/ready handshake.
//  - The block issues one operand per cycle into a 2-stage pipeline:

---
 rtl/lut_mult_pkg.sv | 13 +
 rtl/lut_mult_const8.sv | 20 ++
 rtl/lut_mult_rr_arb.sv | 33 +++
 rtl/lut_mult_share_ctrl.sv | 127 ++++++++++++
 tb/tb_lut_mult_share_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lut_mult_pkg.sv
// Shared widths and helpers for the LUT multiplier sharing controller.
// Imported by lut_mult_share_ctrl and its sub-modules.
package lut_mult_pkg;

  localparam int LUT_X_W = 8;
  localparam int LUT_C_W = 16;

  // A single requester still needs a 1-bit ID bus.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lut_mult_const8.sv
// 8-bit constant multiplier built as a 256-entry lookup table.
// The table is elaborated from A_const; the datapath is a pure read.
module lut_mult_const8
  import lut_mult_pkg::*;
#(
  parameter int A_const = 2
) (
  input  logic [LUT_X_W-1:0] i_x,
  output logic [LUT_C_W-1:0] o_p
);

  logic [LUT_C_W-1:0] w_rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign w_rom[i] = LUT_C_W'(i * A_const);
  end

  assign o_p = w_rom[i_x];

endmodule

// File: rtl/lut_mult_rr_arb.sv
// Round-robin arbiter: grants the first active request after i_ptr.
// Produces a one-hot grant and its encoded index.
module lut_mult_rr_arb
  import lut_mult_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    int   j;
    logic found;
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (i_en && !found && i_req[j]) begin
        found    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/lut_mult_share_ctrl.sv
// Round-robin sharing of one LUT constant multiplier among NUM_REQ lanes.
// Optional perf counters: define LUT_MULT_SHARE_PERF_EN.
module lut_mult_share_ctrl
  import lut_mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_CONST = 2,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [LUT_X_W*NUM_REQ-1:0] req_x,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [LUT_C_W-1:0]         res_data,
  output logic [ID_W-1:0]            res_id
`ifdef LUT_MULT_SHARE_PERF_EN
  ,
  output logic [15:0]                perf_grant_cnt,
  output logic [15:0]                perf_stall_cnt
`endif
);

  logic               r_iss_valid;
  logic [LUT_X_W-1:0] r_iss_x;
  logic [ID_W-1:0]    r_iss_id;
  logic [ID_W-1:0]    r_ptr;
  logic               r_res_valid;
  logic [LUT_C_W-1:0] r_res_data;
  logic [ID_W-1:0]    r_res_id;

  logic               w_stall;
  logic               w_can_acc;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic [LUT_X_W-1:0] w_x;
  logic [LUT_C_W-1:0] w_prod;

  assign w_stall   = r_res_valid & ~res_ready;
  assign w_can_acc = ~r_iss_valid | ~w_stall;
  assign w_any     = |w_gnt;

  // Gate with rst_n so no grant is visible while reset is held.
  lut_mult_rr_arb #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_can_acc & rst_n),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_comb begin
    w_x = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_x = req_x[i*LUT_X_W +: LUT_X_W];
    end
  end

  lut_mult_const8 #(
    .A_const (A_CONST)
  ) u_mult (
    .i_x (r_iss_x),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_valid <= 1'b0;
      r_iss_x     <= '0;
      r_iss_id    <= '0;
      r_ptr       <= ID_W'(NUM_REQ - 1);
    end else if (w_can_acc) begin
      r_iss_valid <= w_any;
      if (w_any) begin
        r_iss_x  <= w_x;
        r_iss_id <= w_idx;
        r_ptr    <= w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else if (!w_stall) begin
      r_res_valid <= r_iss_valid;
      if (r_iss_valid) begin
        r_res_data <= w_prod;
        r_res_id   <= r_iss_id;
      end
    end
  end

  assign req_ready = w_gnt;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

`ifdef LUT_MULT_SHARE_PERF_EN
  logic [15:0] r_grant_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_any && r_grant_cnt != 16'hFFFF)
        r_grant_cnt <= r_grant_cnt + 16'd1;
      if (w_stall && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign perf_grant_cnt = r_grant_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_lut_mult_share_ctrl.sv
// Self-checking bench for lut_mult_share_ctrl (NUM_REQ=4, A_CONST=2).
// A second instance with A_CONST=255 covers the top multiplier boundary.
module tb_lut_mult_share_ctrl;

  localparam int N = 4;
  localparam int A = 2;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          age;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_x;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic [3:0]  rdy2;
  logic        vld2;
  logic [15:0] data2;
  logic [1:0]  id2;
`ifdef LUT_MULT_SHARE_PERF_EN
  logic [15:0] pg, ps, pg2, ps2;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lut_mult_share_ctrl #(.NUM_REQ(N), .A_CONST(A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
`ifdef LUT_MULT_SHARE_PERF_EN
    ,
    .perf_grant_cnt (pg),
    .perf_stall_cnt (ps)
`endif
  );

  lut_mult_share_ctrl #(.NUM_REQ(N), .A_CONST(255)) dut255 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (rdy2),
    .res_valid (vld2),
    .res_ready (res_ready),
    .res_data  (data2),
    .res_id    (id2)
`ifdef LUT_MULT_SHARE_PERF_EN
    ,
    .perf_grant_cnt (pg2),
    .perf_stall_cnt (ps2)
`endif
  );

  function automatic logic [15:0] mulref(input logic [7:0] x, input int a);
    return 16'(int'(x) * a);
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_x     = 32'h11223344;
    res_ready = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0) $display("FAIL rst_ready got=%b exp=0000", req_ready);
    else n_pass++;
    n_chk++;
    if (res_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", res_valid);
    else n_pass++;
    n_chk++;
    if (res_data !== 16'h0) $display("FAIL rst_data got=%h exp=0000", res_data);
    else n_pass++;
    n_chk++;
    if (res_id !== 2'd0) $display("FAIL rst_id got=%0d exp=0", res_id);
    else n_pass++;
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset;
    @(negedge clk);
    req_valid = 4'b0010;
    req_x     = 32'h0000_0500;
    #1;
    n_chk++;
    if (req_ready !== 4'b0010) $display("FAIL single_ready got=%b exp=0010", req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = '0;
    #1;
    n_chk++;
    if (res_valid !== 1'b0) $display("FAIL single_early got=%b exp=0", res_valid);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if (res_valid !== 1'b1 || res_data !== 16'h000A || res_id !== 2'd1)
      $display("FAIL single_res got=%b/%h/%0d exp=1/000a/1", res_valid, res_data, res_id);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if (res_valid !== 1'b0) $display("FAIL single_after got=%b exp=0", res_valid);
    else n_pass++;
  endtask

  task automatic test_fairness;
    do_reset;
    for (int i = 0; i < N; i++) req_x[i*8 +: 8] = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) begin
        n_chk++;
        if (req_ready !== 4'(1 << (k % 4)))
          $display("FAIL fair_grant k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
        else n_pass++;
      end
      if (k >= 2) begin
        n_chk++;
        if (res_valid !== 1'b1 || res_id !== 2'((k - 2) % 4) ||
            res_data !== mulref(req_x[((k-2)%4)*8 +: 8], A))
          $display("FAIL fair_res k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, res_valid,
                   res_id, res_data, (k - 2) % 4, mulref(req_x[((k-2)%4)*8 +: 8], A));
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure;
    int e_rdy [10] = '{1, 2, 0, 0, 0, 4, 8, 0, 0, 0};
    int e_vld [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    int e_id  [10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    do_reset;
    for (int i = 0; i < N; i++) req_x[i*8 +: 8] = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = (k < 7) ? 4'hF : 4'h0;
      res_ready = !(k >= 2 && k <= 4);
      #1;
      n_chk++;
      if (req_ready !== 4'(e_rdy[k]))
        $display("FAIL bp_ready k=%0d got=%b exp=%b", k, req_ready, 4'(e_rdy[k]));
      else n_pass++;
      n_chk++;
      if (res_valid !== 1'(e_vld[k]))
        $display("FAIL bp_valid k=%0d got=%b exp=%0d", k, res_valid, e_vld[k]);
      else n_pass++;
      if (e_vld[k] == 1) begin
        n_chk++;
        if (res_id !== 2'(e_id[k]) || res_data !== mulref(req_x[e_id[k]*8 +: 8], A))
          $display("FAIL bp_res k=%0d got=%0d/%h exp=%0d/%h", k, res_id, res_data,
                   e_id[k], mulref(req_x[e_id[k]*8 +: 8], A));
        else n_pass++;
      end
`ifdef LUT_MULT_SHARE_PERF_EN
      if (k == 7) begin
        n_chk++;
        if (pg !== 16'd4 || ps !== 16'd3)
          $display("FAIL perf_cnt got=%0d/%0d exp=4/3", pg, ps);
        else n_pass++;
      end
`endif
    end
  endtask

  task automatic test_boundary;
    do_reset;
    @(negedge clk);
    req_valid = 4'b0001;
    req_x     = 32'h0000_00FF;
    #1;
    n_chk++;
    if (req_ready !== 4'b0001) $display("FAIL bnd_g0 got=%b exp=0001", req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 4'b0010;
    req_x     = 32'h0000_0000;
    #1;
    n_chk++;
    if (req_ready !== 4'b0010) $display("FAIL bnd_g1 got=%b exp=0010", req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = '0;
    #1;
    n_chk++;
    if (res_valid !== 1'b1 || res_data !== 16'h01FE || res_id !== 2'd0)
      $display("FAIL bnd_ff got=%b/%h/%0d exp=1/01fe/0", res_valid, res_data, res_id);
    else n_pass++;
    n_chk++;
    if (vld2 !== 1'b1 || data2 !== 16'hFE01)
      $display("FAIL bnd_ff255 got=%b/%h exp=1/fe01", vld2, data2);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if (res_valid !== 1'b1 || res_data !== 16'h0000 || res_id !== 2'd1)
      $display("FAIL bnd_zero got=%b/%h/%0d exp=1/0000/1", res_valid, res_data, res_id);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset;
    for (int i = 0; i < N; i++) req_x[i*8 +: 8] = 8'($urandom);
    @(negedge clk);
    req_valid = 4'hF;
    @(negedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    n_chk++;
    if (res_valid !== 1'b1) $display("FAIL mid_full got=%b exp=1", res_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (res_valid !== 1'b0 || req_ready !== 4'b0)
      $display("FAIL mid_drop got=%b/%b exp=0/0000", res_valid, req_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0001 || res_valid !== 1'b0)
      $display("FAIL mid_first got=%b/%b exp=0001/0", req_ready, res_valid);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if (res_valid !== 1'b0) $display("FAIL mid_stale got=%b exp=0", res_valid);
    else n_pass++;
    @(negedge clk);
    req_valid = '0;
    #1;
    n_chk++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== mulref(req_x[7:0], A))
      $display("FAIL mid_res got=%b/%0d/%h exp=1/0/%h", res_valid, res_id, res_data,
               mulref(req_x[7:0], A));
    else n_pass++;
  endtask

  task automatic test_random;
    item_t      q[$];
    int         m_ptr  = N - 1;
    int         last_g = -1;
    int         eg;
    bit         hout, stl, can;
    logic [3:0] v = '0;
    do_reset;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (i == last_g || !v[i]) begin
          v[i] = ($urandom_range(1) == 1);
          if (v[i]) req_x[i*8 +: 8] = 8'($urandom);
        end else if ($urandom_range(9) == 0) begin
          v[i] = 1'b0;
        end
      end
      req_valid = v;
      res_ready = ($urandom_range(3) != 0);
      #1;
      hout = (q.size() > 0) && (q[0].age >= 2);
      stl  = hout && !res_ready;
      can  = !(stl && q.size() >= 2);
      eg   = -1;
      if (can) begin
        for (int k = 1; k <= N; k++) begin
          int j = (m_ptr + k) % N;
          if (eg < 0 && v[j]) eg = j;
        end
      end
      n_chk++;
      if (req_ready !== ((eg < 0) ? 4'b0 : 4'(1 << eg)))
        $display("FAIL rnd_grant c=%0d got=%b exp_idx=%0d", c, req_ready, eg);
      else n_pass++;
      n_chk++;
      if (res_valid !== hout)
        $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, res_valid, hout);
      else n_pass++;
      if (hout) begin
        n_chk++;
        if (res_data !== q[0].data || res_id !== 2'(q[0].id))
          $display("FAIL rnd_res c=%0d got=%0d/%h exp=%0d/%h", c, res_id, res_data,
                   q[0].id, q[0].data);
        else n_pass++;
      end
      @(posedge clk);
      if (hout && res_ready) void'(q.pop_front());
      if (!stl) foreach (q[i]) if (q[i].age < 2) q[i].age++;
      if (eg >= 0) begin
        q.push_back('{eg, mulref(req_x[eg*8 +: 8], A), 1});
        m_ptr = eg;
      end
      last_g = eg;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    req_valid = '0;
    req_x     = '0;
    res_ready = 1'b1;
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_boundary;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
